fft_sequencer: RTL

Top-level controller for the 32-point radix-2 FFT core. On a start handshake it sequences all log2(N) levels × N/2 butterflies, issuing per-butterfly read addresses, twiddle address and ping-pong bank select. It delays each issue by the butterfly pipeline latency to produce matching write strobes and addresses, drains the pipeline between levels, and reports completion. It sits between the system interface and the two data memories, twiddle ROM and butterfly unit.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_sequencer_if.sv | 24 ++
 rtl/fft_delay_line.sv | 24 ++
 rtl/fft_sequencer.sv | 91 +++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and address helpers for the 32-point FFT sequencer.
package fft_pkg;
  localparam int N_LOG2   = 5;
  localparam int BFLY_LAT = 3;
  localparam int ADDR_W   = N_LOG2;
  localparam int IDX_W    = N_LOG2 - 1;
  localparam int LVL_W    = 3;
  localparam int N_BFLY   = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Upper half of {x,x} shifted left is x rotated left by sh (sh <= ADDR_W).
  function automatic logic [ADDR_W-1:0] rotl(input logic [ADDR_W-1:0] x,
                                             input logic [LVL_W-1:0]  sh);
    logic [2*ADDR_W-1:0] w;
    w = {x, x} << sh;
    return w[2*ADDR_W-1 -: ADDR_W];
  endfunction

  // Clears the low (N_LOG2-1-lvl) bits of j.
  function automatic logic [IDX_W-1:0] twiddle(input logic [IDX_W-1:0] j,
                                               input logic [LVL_W-1:0] lvl);
    logic [IDX_W-1:0] m;
    m = {IDX_W{1'b1}} << (LVL_W'(IDX_W) - lvl);
    return j & m;
  endfunction
endpackage

// File: rtl/fft_sequencer_if.sv
// System/memory-side signal bundle of the FFT sequencer; slave is the sequencer view.
interface fft_sequencer_if;
  import fft_pkg::*;
  logic              start;
  logic              ready;
  logic              busy;
  logic              done;
  logic [LVL_W-1:0]  level;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [IDX_W-1:0]  twiddle_addr;
  logic              bank;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;

  modport master (output start,
                  input  ready, busy, done, level, rd_valid, rd_addr_a, rd_addr_b,
                         twiddle_addr, bank, wr_en, wr_addr_a, wr_addr_b);
  modport slave  (input  start,
                  output ready, busy, done, level, rd_valid, rd_addr_a, rd_addr_b,
                         twiddle_addr, bank, wr_en, wr_addr_a, wr_addr_b);
endinterface

// File: rtl/fft_delay_line.sv
// Fixed-depth register delay line with a shift enable; async active-low clear.
module fft_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [DEPTH-1:0][W-1:0] r_pipe;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pipe <= '0;
    end else if (i_en) begin
      r_pipe[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/fft_sequencer.sv
// Radix-2 FFT level/butterfly sequencer with delayed write-back strobes.
// Optional stall input enabled by FFT_SEQ_HOLD_EN.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int LAT = BFLY_LAT
) (
  input logic clk,
  input logic clr_n,
`ifdef FFT_SEQ_HOLD_EN
  input logic hold,
`endif
  fft_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(LAT + 1);

  state_t            r_state, w_next;
  logic [LVL_W-1:0]  r_level;
  logic [IDX_W-1:0]  r_j;
  logic [CNT_W-1:0]  r_dcnt;
  logic              w_adv, w_run, w_last_j, w_last_drain, w_last_lvl;
  logic [2*ADDR_W:0] w_dl_in, w_dl_out;

`ifdef FFT_SEQ_HOLD_EN
  assign w_adv = ~hold;
`else
  assign w_adv = 1'b1;
`endif

  assign w_run        = (r_state == RUN);
  assign w_last_j     = (r_j == IDX_W'(N_BFLY - 1));
  assign w_last_drain = (r_dcnt == CNT_W'(LAT - 1));
  assign w_last_lvl   = (r_level == LVL_W'(N_LOG2 - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last_j) w_next = DRAIN;
      DRAIN:   if (w_last_drain) w_next = w_last_lvl ? DONE : RUN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A held cycle leaves state, counters and the write-side pipe untouched.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_level <= '0;
      r_j     <= '0;
      r_dcnt  <= '0;
    end else if (w_adv) begin
      r_state <= w_next;
      case (r_state)
        RUN:   r_j <= w_last_j ? '0 : r_j + 1'b1;
        DRAIN: begin
          r_dcnt <= w_last_drain ? '0 : r_dcnt + 1'b1;
          if (w_next == RUN) r_level <= r_level + 1'b1;
        end
        DONE:    r_level <= '0;
        default: ;
      endcase
    end
  end

  assign bus.ready        = (r_state == IDLE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = (r_state == DONE);
  assign bus.level        = r_level;
  assign bus.bank         = r_level[0];
  assign bus.rd_valid     = w_run & w_adv;
  // Addresses are zero outside RUN so the delay line drains clean zeros.
  assign bus.rd_addr_a    = w_run ? rotl({r_j, 1'b0}, r_level) : '0;
  assign bus.rd_addr_b    = w_run ? rotl({r_j, 1'b1}, r_level) : '0;
  assign bus.twiddle_addr = w_run ? twiddle(r_j, r_level) : '0;

  assign w_dl_in = {bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b};

  fft_delay_line #(.W(2*ADDR_W + 1), .DEPTH(LAT)) u_wr_dl (
    .clk   (clk),
    .clr_n (clr_n),
    .i_en  (w_adv),
    .i_d   (w_dl_in),
    .o_q   (w_dl_out)
  );

  assign bus.wr_en     = w_dl_out[2*ADDR_W] & w_adv;
  assign bus.wr_addr_a = w_dl_out[2*ADDR_W-1 -: ADDR_W];
  assign bus.wr_addr_b = w_dl_out[ADDR_W-1:0];
endmodule
